// File: rtl/four_to_two_encoder.sv
// Clocked 4-input priority encoder (d highest, a lowest) with an optional
// per-input synchronizer chain and registered index/valid/multi outputs.

module four_to_two_encoder_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);
  generate
    if (STAGES == 0) begin : g_pass
      // Clock and reset are intentionally unused when the lane is a wire.
      logic unused_ok;
      assign unused_ok = clk | rst;
      assign q = din;
    end else begin : g_sr
      logic [STAGES-1:0] sr;
      always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else begin
          sr[0] <= din;
          for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[STAGES-1];
    end
  endgenerate
endmodule

module four_to_two_encoder #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic e0,
  output logic e1,
  output logic valid,
  output logic multi
);
  localparam int NUM_LANES = 4;

  generate
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_param
      $error("four_to_two_encoder: SYNC_STAGES must be 0..3");
    end
  endgenerate

  logic [NUM_LANES-1:0] raw, req;
  logic [1:0]           idx;
  logic                 any, many;

  // Lane index equals priority: raw[3] is d, raw[0] is a.
  assign raw = {d, c, b, a};

  four_to_two_encoder_sync #(.STAGES(SYNC_STAGES)) u_sync [NUM_LANES-1:0] (
    .clk (clk),
    .rst (rst),
    .din (raw),
    .q   (req)
  );

  always_comb begin
    idx = 2'd0;
    if      (req[3]) idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
  end

  assign any  = |req;
  assign many = (req[0] & req[1]) | (req[0] & req[2]) | (req[0] & req[3]) |
                (req[1] & req[2]) | (req[1] & req[3]) | (req[2] & req[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      e1    <= 1'b0;
      e0    <= 1'b0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      e1    <= idx[1];
      e0    <= idx[0];
      valid <= any;
      multi <= many;
    end
  end
endmodule

// File: tb/tb_four_to_two_encoder.sv
// Scoreboard bench: two instances (SYNC_STAGES=0 and 2) share stimulus;
// expectations are queued per vector and popped once the pipeline delivers.

module tb_four_to_two_encoder;
  logic clk = 1'b0;
  logic rst, a, b, c, d;
  logic e0_0, e1_0, valid_0, multi_0;
  logic e0_2, e1_2, valid_2, multi_2;

  always #5 clk = ~clk;

  four_to_two_encoder #(.SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .e0(e0_0), .e1(e1_0), .valid(valid_0), .multi(multi_0)
  );

  four_to_two_encoder #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .e0(e0_2), .e1(e1_2), .valid(valid_2), .multi(multi_2)
  );

  typedef struct {
    logic [3:0] exp;   // {e1,e0,valid,multi}
    string      name;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input exp_t x, input logic [3:0] act);
    checks++;
    if (act !== x.exp) begin
      failures++;
      $display("FAIL %s/%s: got {e1,e0,valid,multi}=%b expected %b",
               tag, x.name, act, x.exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      check("s0", x, {e1_0, e0_0, valid_0, multi_0});
    end
    if (q2.size() > 2) begin
      x = q2.pop_front();
      check("s2", x, {e1_2, e0_2, valid_2, multi_2});
    end
  end

  // Drive one vector for the next rising edge and queue its expectation.
  // A reset also flushes the deeper instance's in-flight vectors to zero.
  task automatic step(input logic [3:0] abcd, input logic r,
                      input logic [3:0] exp, input string name);
    exp_t x;
    {a, b, c, d} = abcd;
    rst = r;
    x.exp  = r ? 4'b0000 : exp;
    x.name = name;
    q0.push_back(x);
    if (r) foreach (q2[i]) q2[i].exp = 4'b0000;
    q2.push_back(x);
    @(negedge clk);
  endtask

  // Hand-computed table for patterns {a,b,c,d} = 0..15.
  logic [3:0] exh [16] = '{
    4'b0000, 4'b1110, 4'b1010, 4'b1111,
    4'b0110, 4'b1111, 4'b1011, 4'b1111,
    4'b0010, 4'b1111, 4'b1011, 4'b1111,
    4'b0111, 4'b1111, 4'b1011, 4'b1111
  };

  initial begin
    // Reset with all requests active, then release.
    step(4'b1111, 1'b1, 4'b0000, "rst0");
    step(4'b1111, 1'b1, 4'b0000, "rst1");
    step(4'b1111, 1'b0, 4'b1111, "post_rst");
    // One-hot sweep.
    step(4'b1000, 1'b0, 4'b0010, "a_only");
    step(4'b0100, 1'b0, 4'b0110, "b_only");
    step(4'b0010, 1'b0, 4'b1010, "c_only");
    step(4'b0001, 1'b0, 4'b1110, "d_only");
    // Exhaustive count, a slowest, d fastest.
    for (int n = 0; n < 16; n++) begin
      logic [3:0] pat;
      pat = 4'(n);
      step(pat, 1'b0, exh[n], $sformatf("exh_%b", pat));
    end
    // Latency: idle then c held.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 4'b0000, "lat_idle");
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 4'b1010, "lat_c");
    // Back-to-back changes.
    step(4'b0100, 1'b0, 4'b0110, "b2b_b");
    step(4'b0001, 1'b0, 4'b1110, "b2b_d");
    step(4'b1000, 1'b0, 4'b0010, "b2b_a");
    step(4'b0000, 1'b0, 4'b0000, "b2b_none");
    // Mid-stream reset while d is held.
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 4'b1110, "mid_d_pre");
    step(4'b0001, 1'b1, 4'b0000, "mid_rst");
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 4'b1110, "mid_d_post");
    // Flush the deeper pipeline so every vector is checked.
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 4'b0000, "flush");
    @(posedge clk);
    #2;
    if (q0.size() != 0 || q2.size() != 2) begin
      failures++;
      $display("FAIL drain: q0=%0d q2=%0d expected 0 and 2", q0.size(), q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
